// File: rtl/phase_freq_est_pkg.sv
// ---------------------------------------------------------------------------
// phase_freq_est_pkg
//
// Shared definitions for the phase/frequency estimation stage and its
// neighbours (the angle calculator uses PI_NEG as well).
//
// Contents:
//   ANGLE_W     width of a binary angle (16)
//   UNWRAP_W    width of the unwrapped phase accumulator (32)
//   state_t     estimator FSM state (S_EMPTY / S_RUN)
//   PI_NEG      binary-angle encoding of -pi
//   sext_angle  sign-extend a binary angle to UNWRAP_W bits
// ---------------------------------------------------------------------------
package phase_freq_est_pkg;

    localparam int ANGLE_W  = 16;
    localparam int UNWRAP_W = 32;

    // Binary angle: full circle is 2^16, so -pi is the most negative code.
    localparam logic [ANGLE_W-1:0] PI_NEG = 16'h8000;

    // S_EMPTY: no previous sample held, the next valid only primes prev.
    // S_RUN:   prev holds the last accepted angle, each valid yields a diff.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    function automatic logic [UNWRAP_W-1:0] sext_angle(input logic [ANGLE_W-1:0] a);
        return {{(UNWRAP_W-ANGLE_W){a[ANGLE_W-1]}}, a};
    endfunction

endpackage

// File: rtl/phase_wrap_diff.sv
// ---------------------------------------------------------------------------
// phase_wrap_diff
//
// Combinational shortest-path difference of two binary angles. The raw
// subtraction is taken modulo 2^16 and reinterpreted as signed, which folds
// any step larger than half a turn onto the opposite direction. A step of
// exactly half a turn comes out as PI_NEG (-32768).
//
// Ports:
//   angle_a  in   16  minuend angle (newer sample)
//   angle_b  in   16  subtrahend angle (older sample)
//   diff     out  16  signed (angle_a - angle_b) mod 2^16
// ---------------------------------------------------------------------------
module phase_wrap_diff
    import phase_freq_est_pkg::*;
(
    input  logic        [ANGLE_W-1:0] angle_a,
    input  logic        [ANGLE_W-1:0] angle_b,
    output logic signed [ANGLE_W-1:0] diff
);

    // Discarding the borrow out of the 16-bit subtraction is the wrap.
    assign diff = $signed(angle_a - angle_b);

endmodule

// File: rtl/phase_freq_est.sv
// ---------------------------------------------------------------------------
// phase_freq_est
//
// Frequency estimator on a sparse binary-angle stream. Each accepted sample
// after the first produces a wrapped phase step against the previous sample;
// 2^N_AVG_LOG2 steps are summed and arithmetically shifted down to give one
// average step (floor toward -inf) per block. prev carries across block
// boundaries, so consecutive blocks need no re-priming.
//
// Handshake: val_i and val_o are valid-only strobes with no ready. Every
// cycle val_i is high delivers one angle that is consumed that cycle; every
// cycle val_o is high presents one estimate that the consumer must take that
// cycle. Payloads are don't-care while their valid is low.
//
// Optional feature (macro PHASE_UNWRAP_OUT_EN): adds unwrap_o / unwrap_val_o,
// a 32-bit running unwrapped phase updated on every accepted sample.
//
// Parameters:
//   N_AVG_LOG2    log2 of steps averaged per estimate (1..8)
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous active-low reset
//   val_i         in   1   angle_i valid
//   angle_i       in   16  signed binary angle
//   clr_i         in   1   synchronous restart, wins over val_i
//   freq_o        out  16  signed average phase step per sample
//   val_o         out  1   one-cycle strobe, freq_o valid
//   unwrap_o      out  32  unwrapped phase       (PHASE_UNWRAP_OUT_EN only)
//   unwrap_val_o  out  1   unwrap_o updated      (PHASE_UNWRAP_OUT_EN only)
//   dbg_state     out  1   current FSM state, for observation only
// ---------------------------------------------------------------------------
module phase_freq_est
    import phase_freq_est_pkg::*;
#(
    parameter int N_AVG_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                val_i,
    input  logic [ANGLE_W-1:0]  angle_i,
    input  logic                clr_i,
    output logic [ANGLE_W-1:0]  freq_o,
    output logic                val_o,
`ifdef PHASE_UNWRAP_OUT_EN
    output logic [UNWRAP_W-1:0] unwrap_o,
    output logic                unwrap_val_o,
`endif
    output state_t              dbg_state
);

    // Room for 2^N steps of magnitude up to 2^15 without overflow.
    localparam int ACC_W = ANGLE_W + N_AVG_LOG2;

    state_t                    state_q;
    state_t                    state_d;
    logic [ANGLE_W-1:0]        prev_q;
    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_sum;
    logic [N_AVG_LOG2-1:0]     cnt_q;
    logic signed [ANGLE_W-1:0] diff;

    // FSM outputs: which kind of sample (if any) is accepted this cycle.
    logic take_first;
    logic take_diff;
    logic block_done;

    assign dbg_state = state_q;

    phase_wrap_diff u_wrap_diff (
        .angle_a (angle_i),
        .angle_b (prev_q),
        .diff    (diff)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = S_EMPTY;
        end else if (val_i) begin
            state_d = S_RUN;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // A sample arriving together with clr_i is dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        take_first = 1'b0;
        take_diff  = 1'b0;
        if (val_i && !clr_i) begin
            case (state_q)
                S_EMPTY: take_first = 1'b1;
                S_RUN:   take_diff  = 1'b1;
                default: take_first = 1'b0;
            endcase
        end
    end

    // The step being added is the last of the block when cnt is all ones.
    assign block_done = take_diff && (cnt_q == {N_AVG_LOG2{1'b1}});

    // Running sum including the current step, sign-extended to ACC_W.
    assign acc_sum = acc_q + {{N_AVG_LOG2{diff[ANGLE_W-1]}}, diff};

    // -----------------------------------------------------------------------
    // Datapath: prev, accumulator, block counter, estimate output
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            freq_o <= '0;
            val_o  <= 1'b0;
        end else if (clr_i) begin
            // freq_o deliberately keeps the last published estimate.
            prev_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            val_o  <= 1'b0;
        end else begin
            val_o <= block_done;
            if (take_first || take_diff) begin
                prev_q <= angle_i;
            end
            if (block_done) begin
                // Dropping the low N bits of the signed sum is the
                // arithmetic shift, i.e. floor toward -inf.
                freq_o <= acc_sum[ACC_W-1:N_AVG_LOG2];
                acc_q  <= '0;
                cnt_q  <= '0;
            end else if (take_diff) begin
                acc_q  <= acc_sum;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

`ifdef PHASE_UNWRAP_OUT_EN
    // -----------------------------------------------------------------------
    // Unwrapped phase: seeded with the first angle, then integrates the
    // wrapped steps so it runs past +/-pi without folding back.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unwrap_o     <= '0;
            unwrap_val_o <= 1'b0;
        end else if (clr_i) begin
            unwrap_o     <= '0;
            unwrap_val_o <= 1'b0;
        end else begin
            unwrap_val_o <= take_first || take_diff;
            if (take_first) begin
                unwrap_o <= sext_angle(angle_i);
            end else if (take_diff) begin
                unwrap_o <= unwrap_o + sext_angle(diff);
            end
        end
    end
`endif

endmodule

// File: tb/tb_phase_freq_est.sv
// ---------------------------------------------------------------------------
// tb_phase_freq_est
//
// Directed bench for phase_freq_est (N_AVG_LOG2 = 4). A reference model works
// on the accepted sample history (queue of wrapped steps, integer floor of the
// mean) and predicts val_o / freq_o for every cycle; a compare process checks
// the DUT at each falling edge. Literal expectations after each scenario pin
// the model's answers.
// ---------------------------------------------------------------------------
module tb_phase_freq_est;
    import phase_freq_est_pkg::*;

    localparam int N   = 4;
    localparam int BLK = 1 << N;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        val_i   = 1'b0;
    logic [15:0] angle_i = 16'd0;
    logic        clr_i   = 1'b0;
    logic [15:0] freq_o;
    logic        val_o;
    state_t      dbg_state;
`ifdef PHASE_UNWRAP_OUT_EN
    logic [31:0] unwrap_o;
    logic        unwrap_val_o;
`endif

    always #5 clk = ~clk;

    phase_freq_est #(.N_AVG_LOG2(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .val_i        (val_i),
        .angle_i      (angle_i),
        .clr_i        (clr_i),
        .freq_o       (freq_o),
        .val_o        (val_o),
`ifdef PHASE_UNWRAP_OUT_EN
        .unwrap_o     (unwrap_o),
        .unwrap_val_o (unwrap_val_o),
`endif
        .dbg_state    (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Scoreboard bookkeeping
    // -----------------------------------------------------------------------
    int          vectors     = 0;
    int          miscompares = 0;
    int          pulse_cnt   = 0;
    logic [15:0] last_freq   = 16'd0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int          diffs[$];
    logic        have_prev = 1'b0;
    int          m_prev    = 0;
    logic        m_val     = 1'b0;
    logic [15:0] m_freq    = 16'd0;
    int          m_sum     = 0;
    logic [31:0] m_unwrap  = 32'd0;
    logic        m_uval    = 1'b0;

    // Shortest signed distance on a 2^16 circle; half a turn reads as -32768.
    function automatic int wrap16(input int d);
        int r;
        r = d & 32'hFFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / BLK;
        return -((-s + BLK - 1) / BLK);
    endfunction

    function automatic int sangle(input logic [15:0] a);
        return (a >= 16'd32768) ? int'(a) - 65536 : int'(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diffs.delete();
            exp_q.delete();
            have_prev = 1'b0;
            m_prev    = 0;
            m_val     = 1'b0;
            m_freq    = 16'd0;
            m_unwrap  = 32'd0;
            m_uval    = 1'b0;
        end else begin
            m_val  = 1'b0;
            m_uval = 1'b0;
            if (clr_i) begin
                diffs.delete();
                have_prev = 1'b0;
                m_unwrap  = 32'd0;
            end else if (val_i) begin
                m_uval = 1'b1;
                if (have_prev) begin
                    diffs.push_back(wrap16(int'(angle_i) - m_prev));
                    m_unwrap = m_unwrap + 32'(diffs[$]);
                    if (diffs.size() == BLK) begin
                        m_sum  = diffs.sum();
                        m_freq = 16'(floor_avg(m_sum));
                        m_val  = 1'b1;
                        exp_q.push_back(m_freq);
                        diffs.delete();
                    end
                end else begin
                    m_unwrap = 32'(sangle(angle_i));
                end
                m_prev    = int'(angle_i);
                have_prev = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compare process: every falling edge once the DUT has seen a clock.
    // -----------------------------------------------------------------------
    logic        started = 1'b0;
    logic [15:0] exp_f;

    always @(negedge clk) begin
        if (started) begin
            check("val_o", {31'd0, val_o}, {31'd0, m_val});
            if (val_o === 1'b1) begin
                pulse_cnt++;
                last_freq = freq_o;
            end
            if (m_val) begin
                exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : m_freq;
                check("freq_o_pulse", {16'd0, freq_o}, {16'd0, exp_f});
            end else begin
                check("freq_o_hold", {16'd0, freq_o}, {16'd0, m_freq});
            end
`ifdef PHASE_UNWRAP_OUT_EN
            check("unwrap_val_o", {31'd0, unwrap_val_o}, {31'd0, m_uval});
            check("unwrap_o", unwrap_o, m_unwrap);
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks (inputs change on falling edges)
    // -----------------------------------------------------------------------
    task automatic drive(input logic v, input logic [15:0] a, input logic c);
        @(negedge clk);
        val_i   = v;
        angle_i = a;
        clr_i   = c;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'd0, 1'b0);
    endtask

    task automatic clear();
        drive(1'b0, 16'd0, 1'b1);
        idle(1);
    endtask

    task automatic ramp(input int start, input int step, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 16'(start + i * step), 1'b0);
            for (int g = 0; g < gap; g++) drive(1'b0, 16'hDEAD, 1'b0);
        end
    endtask

    task automatic alt(input int d0, input int d1);
        int a;
        a = 0;
        drive(1'b1, 16'd0, 1'b0);
        for (int i = 0; i < BLK; i++) begin
            a = a + (((i % 2) == 0) ? d0 : d1);
            drive(1'b1, 16'(a), 1'b0);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    int p0;

    initial begin
        @(posedge clk);
        #1;
        started = 1'b1;
        check("reset_freq", {16'd0, freq_o}, 32'd0);
        check("reset_val", {31'd0, val_o}, 32'd0);
        check("reset_state", {31'd0, dbg_state}, {31'd0, S_EMPTY});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Constant angle: every step is zero.
        p0 = pulse_cnt;
        ramp(1234, 0, BLK + 1, 0);
        idle(2);
        check("const_freq", {16'd0, last_freq}, 32'd0);
        check("const_pulses", 32'(pulse_cnt - p0), 32'd1);

        // +100 ramp, then a second block with no re-priming.
        clear();
        p0 = pulse_cnt;
        ramp(0, 100, BLK + 1, 0);
        idle(2);
        check("ramp_freq", {16'd0, last_freq}, 32'd100);
        ramp(1700, 100, BLK, 0);
        idle(2);
        check("ramp2_freq", {16'd0, last_freq}, 32'd100);
        check("ramp_pulses", 32'(pulse_cnt - p0), 32'd2);

        // +100 ramp crossing +pi (32700 -> -32736).
        clear();
        ramp(32000, 100, BLK + 1, 0);
        idle(2);
        check("wrap_freq", {16'd0, last_freq}, 32'd100);
`ifdef PHASE_UNWRAP_OUT_EN
        check("wrap_unwrap", unwrap_o, 32'd33600);
`endif

        // Alternating steps: floor behaviour and extreme steps.
        clear();
        alt(1, 2);
        idle(2);
        check("alt_pos_freq", {16'd0, last_freq}, 32'd1);
        clear();
        alt(-1, -2);
        idle(2);
        check("alt_neg_freq", {16'd0, last_freq}, 32'(16'hFFFE));
        clear();
        alt(32767, -32768);
        idle(2);
        check("alt_ext_freq", {16'd0, last_freq}, 32'(16'hFFFF));

        // Sparse input: one valid every third cycle.
        clear();
        p0 = pulse_cnt;
        ramp(0, 50, BLK + 1, 2);
        check("sparse_freq", {16'd0, last_freq}, 32'd50);
        check("sparse_pulses", 32'(pulse_cnt - p0), 32'd1);

        // clr with a simultaneous valid discards history.
        clear();
        p0 = pulse_cnt;
        ramp(0, 7, 10, 0);
        drive(1'b1, 16'd70, 1'b1);
        check("clr_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        ramp(500, 7, BLK + 1, 0);
        idle(2);
        check("clr_freq", {16'd0, last_freq}, 32'd7);
        check("clr_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Reset mid-block: outputs clear immediately, no stray pulse.
        ramp(0, 3, 8, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_freq", {16'd0, freq_o}, 32'd0);
        check("rst_mid_val", {31'd0, val_o}, 32'd0);
        check("rst_mid_state", {31'd0, dbg_state}, {31'd0, S_EMPTY});
        idle(2);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        ramp(100, 3, BLK + 1, 0);
        idle(2);
        check("post_rst_freq", {16'd0, last_freq}, 32'd3);
        check("post_rst_pulses", 32'(pulse_cnt - p0), 32'd1);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_freq_est.md
# phase_freq_est

Downstream consumer of the angle stage: takes the 16-bit binary-angle stream (`angle_o`/`val_o` of the angle calculator), computes the wrapped phase difference between consecutive valid samples, and averages 2^N_AVG_LOG2 differences into one frequency estimate per block. It sits between angle extraction and the result/readout logic. Input is sparse (any gaps on `val_i`), and output is one pulse per completed block.

## Interface
- N_AVG_LOG2, default 4, log2 of the number of phase differences averaged per estimate (legal 1..8).
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous, active-low reset
- val_i  input  1  `angle_i` valid this cycle
- angle_i  input  16  signed two's-complement binary angle; -32768 = -π, +32767 = π·(1-2^-15)
- clr_i  input  1  synchronous restart: discard history and partial block
- freq_o  output  16  signed average phase step per sample, same LSB as `angle_i`
- val_o  output  1  one-cycle pulse, `freq_o` valid
- unwrap_o  output  32  unwrapped phase; present only with PHASE_UNWRAP_OUT_EN
- unwrap_val_o  output  1  `unwrap_o` updated; present only with PHASE_UNWRAP_OUT_EN

## Operation
- States: S_EMPTY (no previous sample held), S_RUN (previous sample held).
- S_EMPTY + val_i: store `angle_i` in prev. Go to S_RUN. No difference, cnt stays 0.
- S_RUN + val_i:
  - diff = angle_i - prev, taken modulo 2^16 and read as signed. This yields the shortest-path wrap: +32700 -> -32736 gives +100.
  - A diff of exactly ±π stays -32768.
  - prev <= angle_i.
  - acc (16+N_AVG_LOG2 bits, signed) <= acc + diff; cnt <= cnt + 1.
- Block completion: when the diff being added is the 2^N_AVG_LOG2-th of the block:
  - freq_o <= (acc + diff) >>> N_AVG_LOG2. This is an arithmetic shift, so it floors toward -∞.
  - val_o <= 1.
  - acc <= 0 and cnt <= 0. The next block starts with the next diff; prev carries over, so there is no re-priming.
- val_i low: all state holds and val_o <= 0.
- clr_i high: return to S_EMPTY and zero acc and cnt. freq_o holds its last value and val_o <= 0.
  - clr_i takes priority over a simultaneous val_i; that sample is discarded.
- The accumulator cannot overflow: 2^N diffs of magnitude ≤ 2^15 fit in 16+N bits.

## Timing
- Reset values: freq_o = 0, val_o = 0, unwrap_o = 0, unwrap_val_o = 0. State is S_EMPTY; acc, cnt and prev are 0.
- Reset is asynchronous assert and synchronous release to clk. Reset mid-block discards the partial block, and no val_o follows.
- Latency: val_o rises on the clock edge that samples the block-completing val_i, i.e. one cycle after that val_i.
- val_o is never high for two consecutive cycles unless blocks complete back-to-back (N_AVG_LOG2 = 1 minimum still needs 2 valids).
- Throughput: one sample per clock. There is no backpressure, and val_o must be consumed on the cycle it is high.
- The first estimate after reset or clr needs 2^N_AVG_LOG2 + 1 valid samples.

## Configuration
- PHASE_UNWRAP_OUT_EN defined:
  - Adds the unwrap_o and unwrap_val_o ports.
  - On the S_EMPTY sample, unwrap_o <= sign-extended angle_i.
  - On each S_RUN sample, unwrap_o <= unwrap_o + sign-extended diff, wrapping modulo 2^32.
  - unwrap_val_o pulses with every accepted val_i, one cycle latency.
  - clr_i and reset zero unwrap_o.
- PHASE_UNWRAP_OUT_EN undefined: the ports and register are absent, and the frequency path is unchanged.

## Structure
- Shared package/header holds:
  - ANGLE_W = 16 and UNWRAP_W = 32.
  - State encodings S_EMPTY = 1'b0 and S_RUN = 1'b1.
  - The binary-angle constant PI_NEG = 16'h8000, which the angle calculator uses too.
- Sub-module `phase_wrap_diff` is combinational, computing the signed modulo-2^16 difference of two angles. It is reused by later stages.
- The top holds the FSM, prev, acc, cnt and the output registers.

## Test plan
- Constant angle 1234 for 17 valids -> one val_o with freq_o = 0.
- Ramp +100 per sample from 0, 17 valids -> freq_o = 100. The next 16 valids produce a second pulse with freq_o = 100 (no re-prime).
- Ramp +100 starting at 32000, crossing +π (32700 -> -32736) -> freq_o = 100. With the macro, unwrap_o climbs monotonically past 32767.
- Alternating diffs +1/+2 gives freq_o = 1; alternating -1/-2 gives freq_o = -2 (floor). Alternating +32767/-32768 checks no overflow.
- val_i toggled every third cycle on a +50 ramp -> freq_o = 50, with val_o exactly one cycle after the 17th valid.
- Assert clr_i together with val_i after 10 valids, then send 17 valids at +7 -> no pulse before the restart, then freq_o = 7. Repeat with rst_n low mid-block -> all outputs read 0 immediately.
